// File: rtl/fp_reg_status_file.sv
// Floating-point register file with per-register Tomasulo busy/tag status and CDB snooping.
// Optional same-cycle CDB-to-read forwarding is enabled by defining FPREG_CDB_BYPASS_EN.
module fp_reg_status_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic              rdBusyA,
    output logic              rdBusyB,
    output logic [TAG_W-1:0]  rdTagA,
    output logic [TAG_W-1:0]  rdTagB,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic [TAG_W-1:0]  issueTag,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    output logic [ADDR_W:0]   busyCount
);

    // Register 0 has no storage; it is synthesised as constant zero on the read path.
    logic [DATA_W-1:0] r_value [1:NREGS-1];
    logic [TAG_W-1:0]  r_tag   [1:NREGS-1];
    logic [NREGS-1:1]  r_busy;
    logic [ADDR_W:0]   r_busyCount;

    logic [DATA_W-1:0] w_valueNxt [1:NREGS-1];
    logic [TAG_W-1:0]  w_tagNxt   [1:NREGS-1];
    logic [NREGS-1:1]  w_busyNxt;
    logic [NREGS-1:1]  w_cdbHit;
    logic [ADDR_W:0]   w_countNxt;

    always_comb begin
        w_cdbHit = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            w_cdbHit[i] = cdbValid && (cdbTag != '0) && r_busy[i] && (r_tag[i] == cdbTag);
        end
    end

    // CDB retire first, then issue overrides busy/tag so the newer rename wins.
    always_comb begin
        w_valueNxt = r_value;
        w_tagNxt   = r_tag;
        w_busyNxt  = r_busy;
        w_countNxt = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (w_cdbHit[i]) begin
                w_valueNxt[i] = cdbData;
                w_busyNxt[i]  = 1'b0;
                w_tagNxt[i]   = '0;
            end
            if (issueEn && (issueTag != '0) && (issueAddr == ADDR_W'(i))) begin
                w_busyNxt[i] = 1'b1;
                w_tagNxt[i]  = issueTag;
            end
            w_countNxt = w_countNxt + (ADDR_W+1)'(w_busyNxt[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy      <= '0;
            r_busyCount <= '0;
        end else begin
            r_value     <= w_valueNxt;
            r_tag       <= w_tagNxt;
            r_busy      <= w_busyNxt;
            r_busyCount <= w_countNxt;
        end
    end

    assign busyCount = r_busyCount;

    // Addresses 0 and >= NREGS match no entry and fall through to the zero defaults.
    always_comb begin
        rdDataA = '0;
        rdBusyA = 1'b0;
        rdTagA  = '0;
        rdDataB = '0;
        rdBusyB = 1'b0;
        rdTagB  = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (rdAddrA == ADDR_W'(i)) begin
`ifdef FPREG_CDB_BYPASS_EN
                if (w_cdbHit[i]) begin
                    rdDataA = cdbData;
                end else begin
                    rdDataA = r_value[i];
                    rdBusyA = r_busy[i];
                    rdTagA  = r_tag[i];
                end
`else
                rdDataA = r_value[i];
                rdBusyA = r_busy[i];
                rdTagA  = r_tag[i];
`endif
            end
            if (rdAddrB == ADDR_W'(i)) begin
`ifdef FPREG_CDB_BYPASS_EN
                if (w_cdbHit[i]) begin
                    rdDataB = cdbData;
                end else begin
                    rdDataB = r_value[i];
                    rdBusyB = r_busy[i];
                    rdTagB  = r_tag[i];
                end
`else
                rdDataB = r_value[i];
                rdBusyB = r_busy[i];
                rdTagB  = r_tag[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_reg_status_file.sv
// Scoreboard bench for fp_reg_status_file: a behavioural model predicts reads and busyCount.
// Same-cycle bypass expectations follow FPREG_CDB_BYPASS_EN.
module tb_fp_reg_status_file;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int TW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rdAddrA, rdAddrB;
    logic [DW-1:0] rdDataA, rdDataB;
    logic          rdBusyA, rdBusyB;
    logic [TW-1:0] rdTagA, rdTagB;
    logic          issueEn;
    logic [AW-1:0] issueAddr;
    logic [TW-1:0] issueTag;
    logic          cdbValid;
    logic [TW-1:0] cdbTag;
    logic [DW-1:0] cdbData;
    logic [AW:0]   busyCount;

    always #5 clock = ~clock;

    fp_reg_status_file #(
        .DATA_W(DW),
        .NREGS (NR),
        .ADDR_W(AW),
        .TAG_W (TW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rdAddrA  (rdAddrA),
        .rdAddrB  (rdAddrB),
        .rdDataA  (rdDataA),
        .rdDataB  (rdDataB),
        .rdBusyA  (rdBusyA),
        .rdBusyB  (rdBusyB),
        .rdTagA   (rdTagA),
        .rdTagB   (rdTagB),
        .issueEn  (issueEn),
        .issueAddr(issueAddr),
        .issueTag (issueTag),
        .cdbValid (cdbValid),
        .cdbTag   (cdbTag),
        .cdbData  (cdbData),
        .busyCount(busyCount)
    );

    typedef struct {
        string         nm;
        bit            portB;
        logic [DW-1:0] d;
        logic          b;
        logic [TW-1:0] t;
        logic [AW:0]   c;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] m_val  [NR];
    logic          m_busy [NR];
    logic [TW-1:0] m_tag  [NR];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] model_count();
        logic [AW:0] c = '0;
        for (int i = 1; i < NR; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Apply one edge to the model using the inputs the bench is holding.
    task automatic model_edge();
        bit hit [NR];
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 1; i < NR; i++)
            hit[i] = cdbValid && cdbTag != 0 && m_busy[i] && m_tag[i] == cdbTag;
        for (int i = 1; i < NR; i++) begin
            if (hit[i]) begin
                m_val[i]  = cdbData;
                m_busy[i] = 1'b0;
                m_tag[i]  = '0;
            end
        end
        if (issueEn && issueTag != 0 && issueAddr != 0 && int'(issueAddr) < NR) begin
            m_busy[issueAddr] = 1'b1;
            m_tag[issueAddr]  = issueTag;
        end
    endtask

    task automatic drive(input logic ie, input int ia, input int it,
                         input logic cv, input int ct, input logic [DW-1:0] cd);
        @(negedge clock);
        issueEn   = ie;
        issueAddr = AW'(ia);
        issueTag  = TW'(it);
        cdbValid  = cv;
        cdbTag    = TW'(ct);
        cdbData   = cd;
    endtask

    task automatic commit();
        @(posedge clock);
        model_edge();
        #1;
        issueEn  = 1'b0;
        cdbValid = 1'b0;
    endtask

    task automatic op(input logic ie, input int ia, input int it,
                      input logic cv, input int ct, input logic [DW-1:0] cd);
        drive(ie, ia, it, cv, ct, cd);
        commit();
    endtask

    task automatic push_exp(input string nm, input bit pb, input logic [DW-1:0] d,
                            input logic b, input logic [TW-1:0] t);
        exp_t e;
        e.nm = nm; e.portB = pb; e.d = d; e.b = b; e.t = t; e.c = model_count();
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.portB) begin
                check_val({e.nm, ".dataB"}, 32'(rdDataB), 32'(e.d));
                check_val({e.nm, ".busyB"}, 32'(rdBusyB), 32'(e.b));
                check_val({e.nm, ".tagB"},  32'(rdTagB),  32'(e.t));
            end else begin
                check_val({e.nm, ".dataA"}, 32'(rdDataA), 32'(e.d));
                check_val({e.nm, ".busyA"}, 32'(rdBusyA), 32'(e.b));
                check_val({e.nm, ".tagA"},  32'(rdTagA),  32'(e.t));
            end
            check_val({e.nm, ".count"}, 32'(busyCount), 32'(e.c));
        end
    endtask

    task automatic probe(input string nm, input bit pb, input int addr);
        if (pb) rdAddrB = AW'(addr);
        else    rdAddrA = AW'(addr);
        if (addr > 0 && addr < NR) push_exp(nm, pb, m_val[addr], m_busy[addr], m_tag[addr]);
        else                       push_exp(nm, pb, '0, 1'b0, '0);
        drain();
    endtask

    initial begin
        reset = 1'b1;
        rdAddrA = '0; rdAddrB = '0;
        issueEn = 1'b0; issueAddr = '0; issueTag = '0;
        cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
        model_clear();
        commit();
        commit();
        reset = 1'b0;
        probe("rst0_r3", 1'b0, 3);
        probe("rst0_r7", 1'b1, 7);

        // Random activity, then reset with live inputs that must be discarded.
        for (int n = 0; n < 10; n++)
            op($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7), DW'($urandom));
        probe("rand_r2", 1'b0, 2);
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 4, 3, 1'b1, 3, 16'hF00D);
            reset = 1'b1;
            commit();
        end
        reset = 1'b0;
        for (int r = 1; r < NR; r++) probe($sformatf("rst_r%0d", r), 1'b0, r);

        op(1'b1, 3, 5, 1'b0, 0, '0);
        probe("ren_r3", 1'b0, 3);
        op(1'b0, 0, 0, 1'b1, 5, 16'h1234);
        probe("ret_r3", 1'b0, 3);

        op(1'b1, 2, 2, 1'b0, 0, '0);
        op(1'b1, 4, 2, 1'b0, 0, '0);
        op(1'b1, 2, 6, 1'b0, 0, '0);
        probe("race_pre_r2", 1'b1, 2);
        op(1'b0, 0, 0, 1'b1, 2, 16'h00AA);
        probe("race_r4", 1'b0, 4);
        probe("race_r2", 1'b1, 2);
        op(1'b0, 0, 0, 1'b1, 6, 16'h0777);
        probe("race_r2b", 1'b1, 2);

        op(1'b1, 1, 3, 1'b0, 0, '0);
        op(1'b1, 1, 7, 1'b1, 3, 16'h0055);
        probe("simul_r1", 1'b0, 1);

        op(1'b1, 0, 4, 1'b0, 0, '0);
        op(1'b1, 5, 0, 1'b0, 0, '0);
        probe("r0", 1'b0, 0);
        probe("r5_illegal", 1'b1, 5);
        op(1'b0, 0, 0, 1'b1, 0, 16'hDEAD);
        probe("cdb_tag0_r5", 1'b1, 5);

        op(1'b1, 6, 1, 1'b0, 0, '0);
        drive(1'b0, 0, 0, 1'b1, 1, 16'hBEEF);
        rdAddrB = AW'(6);
`ifdef FPREG_CDB_BYPASS_EN
        push_exp("byp_same", 1'b1, 16'hBEEF, 1'b0, '0);
`else
        push_exp("byp_same", 1'b1, m_val[6], 1'b1, 3'd1);
`endif
        drain();
        commit();
        probe("byp_next", 1'b1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_reg_status_file.md
# fp_reg_status_file

Parametrised floating-point register file with per-register Tomasulo status (busy bit and producer tag). It sits between the issue stage and the reservation stations. On issue, it supplies operand values or producer tags and renames the destination register. It snoops the common data bus (CDB) to retire results into every register still waiting on the broadcast tag.

## Interface

Parameters:
- DATA_W, 16, width of each register value.
- NREGS, 8, number of architectural registers; register 0 is a constant zero.
- ADDR_W, 3, register address width; must satisfy 2^ADDR_W >= NREGS.
- TAG_W, 3, reservation-station tag width; tag value 0 is never issued.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rdAddrA  in  ADDR_W  operand A read address.
- rdAddrB  in  ADDR_W  operand B read address.
- rdDataA  out  DATA_W  operand A value (combinational).
- rdDataB  out  DATA_W  operand B value (combinational).
- rdBusyA  out  1  operand A is awaiting a producer.
- rdBusyB  out  1  operand B is awaiting a producer.
- rdTagA  out  TAG_W  producer tag for A; 0 when not busy.
- rdTagB  out  TAG_W  producer tag for B; 0 when not busy.
- issueEn  in  1  rename the destination this cycle.
- issueAddr  in  ADDR_W  destination register being renamed.
- issueTag  in  TAG_W  tag of the reservation station producing it.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  broadcasting tag.
- cdbData  in  DATA_W  broadcast result.
- busyCount  out  ADDR_W+1  registered count of busy registers.

## Operation

- **State per register i (1..NREGS-1):** value[i], busy[i], tag[i].
- **Register 0:** reads value 0, busy 0, tag 0. Never written. Never renamed.
- **Reads:** combinational from current state. Addresses >= NREGS read as register 0.
- **CDB snoop:** when cdbValid=1, every register with busy=1 and tag==cdbTag loads cdbData and clears busy and tag. Multiple registers may match in one cycle; all update.
- **CDB with non-matching tags:** a broadcast whose tag matches no busy register has no effect. cdbTag=0 never matches.
- **Issue:** when issueEn=1 and issueAddr is in range 1..NREGS-1, set busy=1 and tag=issueTag. The value is unchanged. Issue to address 0 or to an out-of-range address is ignored.
- **Simultaneous CDB match and issue on the same register:**
  - value takes cdbData;
  - busy stays 1 with tag=issueTag (the newer rename wins).
- **Issue with issueTag=0:** illegal. The block ignores the issue.
- **busyCount:** the number of registers with busy=1 after the current edge's updates.
- **Reset** (has priority over issue and CDB):
  - all values 0, all busy 0, all tags 0, busyCount 0;
  - outputs: rdData*=0, rdBusy*=0, rdTag*=0.

## Timing

- Read latency is 0 cycles (combinational).
- Issue and CDB effects are visible on reads from the cycle after the edge.
- With the bypass below disabled, a read in the same cycle as a matching CDB broadcast returns busy=1 and the old tag.
- A same-cycle issue is not visible to reads in that cycle. The issue stage must therefore read sources before renaming the destination, which naturally handles instructions where source equals destination.
- busyCount is registered and lags state by 0 cycles relative to the edge, i.e. it is valid in the same cycle the new state is.
- Reset asserted mid-burst clears all state at that edge. Issue and CDB inputs during reset cycles are discarded.

## Configuration

- **FPREG_CDB_BYPASS_EN defined:**
  - In a cycle where cdbValid=1 and a read port addresses a busy register whose tag equals cdbTag, that port outputs rdData=cdbData, rdBusy=0, rdTag=0.
  - State updates are unchanged.
- **FPREG_CDB_BYPASS_EN undefined:** no forwarding. Reads reflect registered state only, as described under Timing.

## Test plan

- **Reset values:** assert reset for 2 cycles after random activity -> all reads on R1..R7 return data 0, busy 0, tag 0; busyCount=0.
- **Rename then retire:** issue R3 with tag 5 -> next cycle rdAddrA=3 gives busy 1, tag 5, busyCount=1. Then CDB tag 5 data 0x1234 -> next cycle data 0x1234, busy 0, busyCount=0.
- **Multi-match and rename race:**
  - issue R2 and R4 with tag 2; then issue R2 with tag 6;
  - CDB tag 2 data 0x00AA -> R4 = 0x00AA, not busy; R2 still busy, tag 6;
  - a later CDB with tag 6 and any data updates R2.
- **Simultaneous issue and CDB on the same register:** R1 busy tag 3; same cycle CDB tag 3 data 0x0055 and issue R1 tag 7 -> R1 value 0x0055, busy 1, tag 7.
- **Register 0 and illegal issue:** issue address 0 with tag 4, and issue R5 with tag 0 -> both ignored; R0 reads 0/0/0; R5 is unchanged.
- **Bypass:** R6 busy tag 1; CDB tag 1 data 0xBEEF with rdAddrB=6 in the same cycle:
  - with FPREG_CDB_BYPASS_EN, rdDataB=0xBEEF and rdBusyB=0 in that cycle;
  - without it, rdBusyB=1 and rdTagB=1;
  - in both builds, the next cycle reads 0xBEEF and not busy.
